// File: rtl/idelay_cal_ctrl.sv
// Per-lane IODELAY tap sweep: loads every tap, checks the ADC test pattern, then centres
// each lane on its longest contiguous passing window and loads that tap back.
module idelay_cal_ctrl #(
   parameter int NUM_LANES     = 8,
   parameter int SETTLE_CYCLES = 16,
   parameter int CHECK_SAMPLES = 64,
   parameter int MIN_WINDOW    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NUM_LANES-1:0]   data_p,
   input  logic [NUM_LANES-1:0]   data_n,
   input  logic [NUM_LANES-1:0]   exp_p,
   input  logic [NUM_LANES-1:0]   exp_n,
   output logic [NUM_LANES-1:0]   delay_ld,
   output logic [4:0]             delay_wdata,
   output logic                   busy,
   output logic                   done,
   output logic [NUM_LANES-1:0]   lane_ok,
   output logic [5*NUM_LANES-1:0] lane_tap
);

   localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_SAMPLES) ? SETTLE_CYCLES : CHECK_SAMPLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [3:0] {
      IDLE, LOAD, SETTLE, CHECK, NEXT_TAP, EVAL, APPLY, NEXT_LANE, DONE
   } state_t;

   state_t                 r_state;
   logic [LANE_W-1:0]      r_lane;
   logic [4:0]             r_tap;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_pass;
   logic [31:0]            r_map;
   logic [4:0]             r_scan;
   logic [5:0]             r_run_len;
   logic [4:0]             r_run_start;
   logic [5:0]             r_best_len;
   logic [4:0]             r_best_start;
   logic [NUM_LANES-1:0]   r_delay_ld;
   logic [4:0]             r_delay_wdata;
   logic                   r_busy;
   logic                   r_done;
   logic [NUM_LANES-1:0]   r_lane_ok;
   logic [5*NUM_LANES-1:0] r_lane_tap;

   logic                   w_match;
   logic                   w_bit;
   logic [5:0]             w_run_len_nxt;
   logic [4:0]             w_run_start_nxt;
   logic [5:0]             w_best_len_nxt;
   logic [4:0]             w_best_start_nxt;
   logic [4:0]             w_center;
   logic                   w_lane_ok;
   logic [4:0]             w_final_tap;
   logic [NUM_LANES-1:0]   w_onehot;
   logic [NUM_LANES-1:0]   w_onehot_next;

   // NOTE: one EVAL scan step is computed combinationally so the last EVAL cycle can commit
   // the updated best run directly; the flop block below then uses only non-blocking writes.
   always_comb begin
      w_match          = (data_p[r_lane] == exp_p[r_lane]) && (data_n[r_lane] == exp_n[r_lane]);
      w_bit            = r_map[r_scan];
      w_run_start_nxt  = (r_run_len == 6'd0) ? r_scan : r_run_start;
      w_run_len_nxt    = w_bit ? (r_run_len + 6'd1) : 6'd0;
      w_best_len_nxt   = r_best_len;
      w_best_start_nxt = r_best_start;
      // Strictly longer replaces the best, so ties keep the lowest-start run.
      if (w_bit && (w_run_len_nxt > r_best_len)) begin
         w_best_len_nxt   = w_run_len_nxt;
         w_best_start_nxt = w_run_start_nxt;
      end
      w_center      = w_best_start_nxt + 5'((w_best_len_nxt - 6'd1) >> 1);
      w_lane_ok     = (int'(w_best_len_nxt) >= MIN_WINDOW);
      w_final_tap   = w_lane_ok ? w_center : 5'd0;
      w_onehot      = NUM_LANES'(1) << r_lane;
      w_onehot_next = NUM_LANES'(1) << (r_lane + LANE_W'(1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_lane        <= '0;
         r_tap         <= '0;
         r_cnt         <= '0;
         r_pass        <= 1'b0;
         r_map         <= '0;
         r_scan        <= '0;
         r_run_len     <= '0;
         r_run_start   <= '0;
         r_best_len    <= '0;
         r_best_start  <= '0;
         r_delay_ld    <= '0;
         r_delay_wdata <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_lane_ok     <= '0;
         r_lane_tap    <= '0;
      end else begin
         // Load strobes are raised on entry to LOAD/APPLY and dropped after one cycle.
         r_delay_ld <= '0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_lane        <= '0;
                  r_tap         <= '0;
                  r_map         <= '0;
                  r_busy        <= 1'b1;
                  r_done        <= 1'b0;
                  r_lane_ok     <= '0;
                  r_lane_tap    <= '0;
                  r_delay_ld    <= NUM_LANES'(1);
                  r_delay_wdata <= 5'd0;
                  r_state       <= LOAD;
               end
            end
            LOAD: begin
               r_cnt   <= '0;
               r_state <= SETTLE;
            end
            SETTLE: begin
               if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                  r_cnt   <= '0;
                  r_pass  <= 1'b1;
                  r_state <= CHECK;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            CHECK: begin
               r_pass <= r_pass & w_match;
               if (r_cnt == CNT_W'(CHECK_SAMPLES - 1)) begin
                  r_cnt   <= '0;
                  r_state <= NEXT_TAP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            NEXT_TAP: begin
               r_map[r_tap] <= r_pass;
               if (r_tap == 5'd31) begin
                  r_scan       <= '0;
                  r_run_len    <= '0;
                  r_run_start  <= '0;
                  r_best_len   <= '0;
                  r_best_start <= '0;
                  r_state      <= EVAL;
               end else begin
                  r_tap         <= r_tap + 5'd1;
                  r_delay_ld    <= w_onehot;
                  r_delay_wdata <= r_tap + 5'd1;
                  r_state       <= LOAD;
               end
            end
            EVAL: begin
               r_run_len    <= w_run_len_nxt;
               r_run_start  <= w_run_start_nxt;
               r_best_len   <= w_best_len_nxt;
               r_best_start <= w_best_start_nxt;
               r_scan       <= r_scan + 5'd1;
               if (r_scan == 5'd31) begin
                  r_lane_ok[r_lane]          <= w_lane_ok;
                  r_lane_tap[r_lane*5 +: 5]  <= w_final_tap;
                  r_delay_ld                 <= w_onehot;
                  r_delay_wdata              <= w_final_tap;
                  r_state                    <= APPLY;
               end
            end
            APPLY: begin
               r_state <= NEXT_LANE;
            end
            NEXT_LANE: begin
               if (r_lane == LANE_W'(NUM_LANES - 1)) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_lane        <= r_lane + LANE_W'(1);
                  r_tap         <= '0;
                  r_map         <= '0;
                  r_delay_ld    <= w_onehot_next;
                  r_delay_wdata <= 5'd0;
                  r_state       <= LOAD;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign delay_ld    = r_delay_ld;
   assign delay_wdata = r_delay_wdata;
   assign busy        = r_busy;
   assign done        = r_done;
   assign lane_ok     = r_lane_ok;
   assign lane_tap    = r_lane_tap;

endmodule
